// File: rtl/mbm_pkg.sv
// Shared widths and tag types for the two-requester Booth multiplier arbiter.
package mbm_pkg;

    localparam int MBM_OPW = 8;
    localparam int MBM_PW  = 16;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } mbm_tag_t;

endpackage

// File: rtl/mbm_arbiter_if.sv
// Operand/result handshakes for both requesters plus the external multiplier hookup.
interface mbm_arbiter_if;

    logic                         req0_valid;
    logic                         req0_ready;
    logic [mbm_pkg::MBM_OPW-1:0]  req0_a;
    logic [mbm_pkg::MBM_OPW-1:0]  req0_b;
    logic                         req1_valid;
    logic                         req1_ready;
    logic [mbm_pkg::MBM_OPW-1:0]  req1_a;
    logic [mbm_pkg::MBM_OPW-1:0]  req1_b;

    logic                         res0_valid;
    logic                         res0_ready;
    logic [mbm_pkg::MBM_PW-1:0]   res0_p;
    logic                         res1_valid;
    logic                         res1_ready;
    logic [mbm_pkg::MBM_PW-1:0]   res1_p;

    logic [mbm_pkg::MBM_OPW-1:0]  mul_a;
    logic [mbm_pkg::MBM_OPW-1:0]  mul_b;
    logic [mbm_pkg::MBM_PW-1:0]   mul_p;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready,
        output res0_valid, res0_p, res1_valid, res1_p,
        input  res0_ready, res1_ready,
        output mul_a, mul_b,
        input  mul_p
    );

    // Requester / multiplier side
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  res0_valid, res0_p, res1_valid, res1_p,
        output res0_ready, res1_ready,
        input  mul_a, mul_b,
        output mul_p
    );

endinterface

// File: rtl/mbm_res_fifo.sv
// Per-requester result FIFO; simultaneous push and pop at full is legal.
module mbm_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    // Data reads as zero while empty so the result bus is quiet between products.
    assign dout   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbm_arbiter.sv
// Round-robin sharing of one external registered multiplier between two requesters.
// Optional MBM_ARB_PERF_EN adds saturating per-requester accept counters.
module mbm_arbiter
    import mbm_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int RES_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    mbm_arbiter_if.slave       bus,
    output logic               busy
`ifdef MBM_ARB_PERF_EN
    ,
    output logic [MBM_PW-1:0]  perf_cnt0,
    output logic [MBM_PW-1:0]  perf_cnt1
`endif
);

    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RES_DEPTH);

    logic [CW-1:0] credit0, credit1;
    logic          elig0, elig1, grant0, grant1;
    logic          pop0, pop1, push0, push1;
    logic          full0, full1, empty0, empty1;
    logic [CW-1:0] cnt0, cnt1;
    logic          tag_busy;
    req_id_t       last_grant;
    mbm_tag_t      tag_q [MUL_LAT];
    mbm_tag_t      tag_last;

    // Credits cover both in-flight products and FIFO occupancy, so a grant
    // always has a FIFO slot reserved by the time its product emerges.
    assign elig0  = bus.req0_valid && (credit0 < CREDIT_MAX) && !rst;
    assign elig1  = bus.req1_valid && (credit1 < CREDIT_MAX) && !rst;
    assign grant0 = elig0 && (!elig1 || last_grant == 1'b1);
    assign grant1 = elig1 && (!elig0 || last_grant == 1'b0);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mul_a = grant0 ? bus.req0_a : (grant1 ? bus.req1_a : '0);
    assign bus.mul_b = grant0 ? bus.req0_b : (grant1 ? bus.req1_b : '0);

    assign tag_last = tag_q[MUL_LAT-1];
    assign push0    = tag_last.valid && (tag_last.id == 1'b0);
    assign push1    = tag_last.valid && (tag_last.id == 1'b1);
    assign pop0     = bus.res0_valid && bus.res0_ready;
    assign pop1     = bus.res1_valid && bus.res1_ready;

    assign bus.res0_valid = !empty0;
    assign bus.res1_valid = !empty1;

    always_comb begin
        tag_busy = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            tag_busy = tag_busy | tag_q[i].valid;
        end
    end

    assign busy = tag_busy || (cnt0 != '0) || (cnt1 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
            last_grant <= 1'b1;
            credit0    <= '0;
            credit1    <= '0;
        end else begin
            tag_q[0] <= '{valid: grant0 | grant1, id: grant1};
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (grant0 || grant1) begin
                last_grant <= grant1;
            end
            if (grant0 && !pop0) begin
                credit0 <= credit0 + 1'b1;
            end else if (!grant0 && pop0) begin
                credit0 <= credit0 - 1'b1;
            end
            if (grant1 && !pop1) begin
                credit1 <= credit1 + 1'b1;
            end else if (!grant1 && pop1) begin
                credit1 <= credit1 - 1'b1;
            end
        end
    end

    mbm_res_fifo #(.DEPTH(RES_DEPTH), .W(MBM_PW)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .pop   (pop0),
        .din   (bus.mul_p),
        .dout  (bus.res0_p),
        .full  (full0),
        .empty (empty0),
        .count (cnt0)
    );

    mbm_res_fifo #(.DEPTH(RES_DEPTH), .W(MBM_PW)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .pop   (pop1),
        .din   (bus.mul_p),
        .dout  (bus.res1_p),
        .full  (full1),
        .empty (empty1),
        .count (cnt1)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push0 && full0 && !pop0));
            assert (!(push1 && full1 && !pop1));
        end
    end
`endif

`ifdef MBM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt0 <= '0;
            perf_cnt1 <= '0;
        end else begin
            if (grant0 && perf_cnt0 != 16'hFFFF) begin
                perf_cnt0 <= perf_cnt0 + 1'b1;
            end
            if (grant1 && perf_cnt1 != 16'hFFFF) begin
                perf_cnt1 <= perf_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mbm_arbiter.sv
// Directed bench for mbm_arbiter with a two-stage registered multiplier model.
module tb_mbm_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mbm_arbiter_if bus ();

`ifdef MBM_ARB_PERF_EN
    logic [15:0] perf_cnt0, perf_cnt1;
`endif

    mbm_arbiter #(.MUL_LAT(2), .RES_DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef MBM_ARB_PERF_EN
        ,
        .perf_cnt0 (perf_cnt0),
        .perf_cnt1 (perf_cnt1)
`endif
    );

    // External multiplier: operands in cycle T, product on mul_p in cycle T+2.
    logic signed [15:0] mp1, mp2;
    always @(posedge clk) begin
        mp1 <= $signed({{8{bus.mul_a[7]}}, bus.mul_a}) * $signed({{8{bus.mul_b[7]}}, bus.mul_b});
        mp2 <= mp1;
    end
    assign bus.mul_p = mp2;

    // Result collector: samples just before the rising edge that commits a pop.
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          vcount = 0;
    always @(negedge clk) begin
        #3;
        if (rst === 1'b0) begin
            if (bus.res0_valid && bus.res0_ready) q0.push_back(bus.res0_p);
            if (bus.res1_valid && bus.res1_ready) q1.push_back(bus.res1_p);
            if (bus.res0_valid || bus.res1_valid) vcount++;
        end
    end

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.res0_ready = 0; bus.res1_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
        q0.delete();
        q1.delete();
        vcount = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        #1;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b expected 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b expected 0", bus.req1_ready); end
        @(negedge clk);
        #1;
        checks++; if (bus.res0_valid !== 1'b0 || bus.res1_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b%b expected 00", bus.res0_valid, bus.res1_valid); end
        checks++; if (bus.res0_p !== 16'h0 || bus.res1_p !== 16'h0) begin errors++; $display("FAIL reset_res_p: got %h %h expected 0000 0000", bus.res0_p, bus.res1_p); end
        checks++; if (bus.mul_a !== 8'h0 || bus.mul_b !== 8'h0) begin errors++; $display("FAIL reset_mul_ops: got %h %h expected 00 00", bus.mul_a, bus.mul_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        idle_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        bus.res0_ready = 1;
        bus.req0_valid = 1; bus.req0_a = 8'd3; bus.req0_b = 8'hFB;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", bus.req0_ready); end
        checks++; if (bus.mul_a !== 8'd3 || bus.mul_b !== 8'hFB) begin errors++; $display("FAIL single_mul_ops: got %h %h expected 03 fb", bus.mul_a, bus.mul_b); end
        @(negedge clk);
        bus.req0_valid = 0;
        #1;
        checks++; if (bus.res0_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_t1: got valid %b busy %b expected 0 1", bus.res0_valid, busy); end
        checks++; if (bus.mul_a !== 8'h0) begin errors++; $display("FAIL single_mul_idle: got %h expected 00", bus.mul_a); end
        @(negedge clk);
        #1;
        checks++; if (bus.res0_valid !== 1'b0) begin errors++; $display("FAIL single_t2_valid: got %b expected 0", bus.res0_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.res0_valid !== 1'b1 || bus.res0_p !== 16'hFFF1) begin errors++; $display("FAIL single_t3_result: got valid %b p %h expected 1 fff1", bus.res0_valid, bus.res0_p); end
        @(negedge clk);
        #1;
        checks++; if (bus.res0_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after_pop: got valid %b busy %b expected 0 0", bus.res0_valid, busy); end
    endtask

    task automatic test_contention();
        logic [7:0]  a0 [3] = '{8'd2, 8'd4, 8'hF9};
        logic [7:0]  b0 [3] = '{8'd3, 8'd5, 8'd9};
        logic [7:0]  a1 [3] = '{8'd7, 8'd10, 8'h80};
        logic [7:0]  b1 [3] = '{8'hFE, 8'd10, 8'd1};
        logic [15:0] e0 [3] = '{16'h0006, 16'h0014, 16'hFFC1};
        logic [15:0] e1 [3] = '{16'hFFF2, 16'h0064, 16'hFF80};
        int i0 = 0, i1 = 0;
        do_reset();
        bus.res0_ready = 1; bus.res1_ready = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.req0_valid = 1; bus.req0_a = a0[i0 < 3 ? i0 : 2]; bus.req0_b = b0[i0 < 3 ? i0 : 2];
            bus.req1_valid = 1; bus.req1_a = a1[i1 < 3 ? i1 : 2]; bus.req1_b = b1[i1 < 3 ? i1 : 2];
            #1;
            checks++;
            if (bus.req0_ready !== (k % 2 == 0) || bus.req1_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL contention_grant k=%0d: got %b%b expected %b%b", k, bus.req0_ready, bus.req1_ready, (k % 2 == 0), (k % 2 == 1));
            end
            if (bus.req0_ready) i0++;
            if (bus.req1_ready) i1++;
        end
        @(negedge clk);
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (6) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q0.size() <= i || q0[i] !== e0[i]) begin errors++; $display("FAIL contention_res0[%0d]: got %h (n=%0d) expected %h", i, (q0.size() > i) ? q0[i] : 16'hxxxx, q0.size(), e0[i]); end
            checks++;
            if (q1.size() <= i || q1[i] !== e1[i]) begin errors++; $display("FAIL contention_res1[%0d]: got %h (n=%0d) expected %h", i, (q1.size() > i) ? q1[i] : 16'hxxxx, q1.size(), e1[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  a0 [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic [7:0]  b0 [4] = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};
        logic [15:0] e0 [4] = '{16'hFFFE, 16'hFFFA, 16'hFFF4, 16'hFFEC};
        int  i0 = 0, n1 = 0;
        logic exp0, exp1;
        do_reset();
        bus.res0_ready = 0; bus.res1_ready = 1;
        bus.req1_a = 8'd1; bus.req1_b = 8'd1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.req0_valid = 1; bus.req0_a = a0[i0 < 4 ? i0 : 3]; bus.req0_b = b0[i0 < 4 ? i0 : 3];
            bus.req1_valid = 1;
            #1;
            exp0 = (k <= 6) && (k % 2 == 0);
            exp1 = (k % 2 == 1) || (k >= 7);
            checks++;
            if (bus.req0_ready !== exp0 || bus.req1_ready !== exp1) begin
                errors++;
                $display("FAIL backpressure_grant k=%0d: got %b%b expected %b%b", k, bus.req0_ready, bus.req1_ready, exp0, exp1);
            end
            if (bus.req0_ready) i0++;
            if (bus.req1_ready) n1++;
        end
        checks++; if (i0 != 4) begin errors++; $display("FAIL backpressure_accepts0: got %0d expected 4", i0); end
        @(negedge clk);
        bus.req0_valid = 0; bus.req1_valid = 0;
        #1;
        checks++; if (bus.res0_valid !== 1'b1 || q0.size() != 0) begin errors++; $display("FAIL backpressure_held: got valid %b n=%0d expected 1 0", bus.res0_valid, q0.size()); end
        bus.res0_ready = 1;
        repeat (8) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q0.size() <= i || q0[i] !== e0[i]) begin errors++; $display("FAIL backpressure_drain[%0d]: got %h (n=%0d) expected %h", i, (q0.size() > i) ? q0[i] : 16'hxxxx, q0.size(), e0[i]); end
        end
        checks++; if (q1.size() != 8 || n1 != 8) begin errors++; $display("FAIL backpressure_res1_count: got %0d results %0d accepts expected 8 8", q1.size(), n1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a [6] = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'd12, 8'hF6};
        logic [7:0]  b [6] = '{8'h80, 8'h80, 8'hB3, 8'hFF, 8'd12, 8'd5};
        logic [15:0] e [6] = '{16'h4000, 16'hC080, 16'h0000, 16'h0001, 16'h0090, 16'hFFCE};
        do_reset();
        bus.res0_ready = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.req0_valid = 1; bus.req0_a = a[k]; bus.req0_b = b[k];
            #1;
            checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d: got %b expected 1", k, bus.req0_ready); end
        end
        @(negedge clk);
        bus.req0_valid = 0;
        repeat (5) @(negedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (q0.size() <= i || q0[i] !== e[i]) begin errors++; $display("FAIL b2b_product[%0d]: got %h (n=%0d) expected %h", i, (q0.size() > i) ? q0[i] : 16'hxxxx, q0.size(), e[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.res0_ready = 1; bus.res1_ready = 1;
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_a = 8'd2; bus.req0_b = 8'd2;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL midflight_accept0: got %b expected 1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_a = 8'd3; bus.req1_b = 8'd3;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL midflight_accept1: got %b expected 1", bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (vcount != 0) begin errors++; $display("FAIL midflight_no_result: got %0d valid cycles expected 0", vcount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midflight_busy: got %b expected 0", busy); end
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_a = 8'd5; bus.req0_b = 8'hFA;
        bus.req1_valid = 1; bus.req1_a = 8'd9; bus.req1_b = 8'd9;
        #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL midflight_tie: got %b%b expected 10", bus.req0_ready, bus.req1_ready); end
        @(negedge clk);
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (q0.size() != 1 || q0[0] !== 16'hFFE2) begin errors++; $display("FAIL midflight_next_op: got %h (n=%0d) expected ffe2", (q0.size() > 0) ? q0[0] : 16'hxxxx, q0.size()); end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL midflight_res1: got %0d results expected 0", q1.size()); end
    endtask

`ifdef MBM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        bus.res0_ready = 1; bus.res1_ready = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.req0_valid = 1; bus.req0_a = 8'(k); bus.req0_b = 8'd2;
        end
        @(negedge clk);
        bus.req0_valid = 0;
        for (int k = 0; k < 5; k++) begin
            bus.req1_valid = 1; bus.req1_a = 8'(k); bus.req1_b = 8'd3;
            @(negedge clk);
        end
        bus.req1_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (perf_cnt0 !== 16'd10 || perf_cnt1 !== 16'd5) begin errors++; $display("FAIL perf_counts: got %0d %0d expected 10 5", perf_cnt0, perf_cnt1); end
        do_reset();
        #1;
        checks++; if (perf_cnt0 !== 16'd0 || perf_cnt1 !== 16'd0) begin errors++; $display("FAIL perf_reset: got %0d %0d expected 0 0", perf_cnt0, perf_cnt1); end
    endtask
`endif

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
`ifdef MBM_ARB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
